// File: rtl/program_loader.sv
// program_loader
//   Serial boot loader for the LC2K CPU. Receives a big-endian byte stream
//   made of a 32-bit word count N followed by N 32-bit words. It writes word k
//   to memory address k and holds the CPU in halt until the whole image is in
//   memory.
//
//   Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
//   rx_ready depends only on state (HEADER/LOAD), never on rx_valid. The memory
//   side has no backpressure: mem_write_en is a one-cycle strobe per word,
//   with mem_addr/mem_write_data stable while it is high.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   rx_data/valid   : incoming byte and its qualifier
//   rx_ready        : loader accepts a byte this cycle
//   start           : re-arm pulse, honoured only in DONE or ERROR
//   mem_write_en    : one-cycle write strobe
//   mem_addr        : word address of the write
//   mem_write_data  : assembled 32-bit word
//   cpu_halt        : holds the CPU program counter
//   load_done       : image fully written
//   load_error      : header rejected (N==0 or N > 2^ADDR_WIDTH)
//   words_loaded    : number of words written so far
//   dbg_state       : current FSM state (0 HEADER, 1 LOAD, 2 DONE, 3 ERROR)
module program_loader #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  start,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_write_data,
    output logic                  cpu_halt,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] ONE_W = 1;

    state_t                r_state;
    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_shift;      // first three bytes of the current group
    logic [31:0]           r_count;      // latched image size N
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_data;
    logic                  r_cpu_halt;
    logic                  r_load_done;
    logic                  r_load_error;
    logic [ADDR_WIDTH:0]   r_words;

    logic        w_rx_ready;
    logic        w_accept;
    logic        w_last_byte;
    logic [31:0] w_word;
    logic [31:0] w_next_words;
    logic [32:0] w_max_n;
    logic        w_bad_hdr;

    assign w_rx_ready   = (r_state == ST_HEADER) || (r_state == ST_LOAD);
    assign w_accept     = rx_valid && w_rx_ready;
    assign w_last_byte  = (r_byte_cnt == 2'd3);
    assign w_word       = {r_shift, rx_data};
    assign w_next_words = 32'(r_words) + 32'd1;
    // Header check is done at full width so large N never aliases into range.
    assign w_max_n      = 33'd1 << ADDR_WIDTH;
    assign w_bad_hdr    = (w_word == 32'd0) || ({1'b0, w_word} > w_max_n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_HEADER;
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'd0;
            r_count      <= 32'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= 32'd0;
            r_cpu_halt   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_words      <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_HEADER: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (!w_last_byte) begin
                            r_shift <= {r_shift[15:0], rx_data};
                        end else if (w_bad_hdr) begin
                            r_state      <= ST_ERROR;
                            r_load_error <= 1'b1;
                        end else begin
                            r_count <= w_word;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (!w_last_byte) begin
                            r_shift <= {r_shift[15:0], rx_data};
                        end else begin
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= r_words[ADDR_WIDTH-1:0];
                            r_mem_data <= w_word;
                            r_words    <= r_words + ONE_W;
                            if (w_next_words == r_count) begin
                                r_state     <= ST_DONE;
                                r_load_done <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_HEADER;
                        r_load_done <= 1'b0;
                        r_words     <= '0;
                        r_cpu_halt  <= 1'b1;
                        r_byte_cnt  <= 2'd0;
                    end else begin
                        // First DONE edge ends the final write cycle, so the
                        // CPU is released only once the last word is stored.
                        r_cpu_halt <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    if (start) begin
                        r_state      <= ST_HEADER;
                        r_load_error <= 1'b0;
                        r_byte_cnt   <= 2'd0;
                    end
                end
                default: r_state <= ST_HEADER;
            endcase
        end
    end

    assign rx_ready       = w_rx_ready;
    assign mem_write_en   = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_data;
    assign cpu_halt       = r_cpu_halt;
    assign load_done      = r_load_done;
    assign load_error     = r_load_error;
    assign words_loaded   = r_words;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  // DUT A: default ADDR_WIDTH=16
  logic [7:0]  rx_data_a;
  logic        rx_valid_a, rx_ready_a, start_a, we_a, halt_a, done_a, err_a;
  logic [15:0] addr_a;
  logic [31:0] wdata_a;
  logic [16:0] words_a;
  logic [1:0]  state_a;

  // DUT B: ADDR_WIDTH=2 for boundary cases
  logic [7:0]  rx_data_b;
  logic        rx_valid_b, rx_ready_b, start_b, we_b, halt_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  words_b;
  logic [1:0]  state_b;

  program_loader #(.ADDR_WIDTH(16)) u_dut_a (
    .clk(clk), .reset(rst_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready_a), .start(start_a), .mem_write_en(we_a), .mem_addr(addr_a),
    .mem_write_data(wdata_a), .cpu_halt(halt_a), .load_done(done_a),
    .load_error(err_a), .words_loaded(words_a), .dbg_state(state_a)
  );

  program_loader #(.ADDR_WIDTH(2)) u_dut_b (
    .clk(clk), .reset(rst_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready_b), .start(start_b), .mem_write_en(we_b), .mem_addr(addr_b),
    .mem_write_data(wdata_b), .cpu_halt(halt_b), .load_done(done_b),
    .load_error(err_b), .words_loaded(words_b), .dbg_state(state_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] exp_q_a[$];
  logic [47:0] exp_q_b[$];
  logic [47:0] e_a, e_b;
  logic prev_we_a = 1'b0;
  logic prev_we_b = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we_a) begin
      if (prev_we_a) chk("a_we_back_to_back", 1, 0);
      if (exp_q_a.size() == 0) chk("a_unexpected_write", 1, 0);
      else begin
        e_a = exp_q_a.pop_front();
        chk("a_wr_addr", addr_a, e_a[47:32]);
        chk("a_wr_data", wdata_a, e_a[31:0]);
      end
    end
    prev_we_a = we_a;
    if (we_b) begin
      if (prev_we_b) chk("b_we_back_to_back", 1, 0);
      if (exp_q_b.size() == 0) chk("b_unexpected_write", 1, 0);
      else begin
        e_b = exp_q_b.pop_front();
        chk("b_wr_addr", addr_b, e_b[47:32]);
        chk("b_wr_data", wdata_b, e_b[31:0]);
      end
    end
    prev_we_b = we_b;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_byte(input int sel, input logic [7:0] b);
    int budget = 0;
    while (((sel == 0) ? rx_ready_a : rx_ready_b) !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) chk("rx_ready_timeout", 0, 1);
    if (sel == 0) begin rx_data_a = b; rx_valid_a = 1'b1; end
    else          begin rx_data_b = b; rx_valid_b = 1'b1; end
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int maxg);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, maxg)) @(negedge clk);
      send_byte(sel, w[31-8*i -: 8]);
    end
  endtask

  task automatic push_send(input int sel, input logic [15:0] addr, input logic [31:0] w,
                           input int maxg);
    if (sel == 0) exp_q_a.push_back({addr, w});
    else          exp_q_b.push_back({addr, w});
    send_word(sel, w, maxg);
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  logic [31:0] nom_words [3];

  // ---------------- main sequence ----------------
  initial begin
    nom_words[0] = 32'h0081_0005;
    nom_words[1] = 32'h0100_0007;
    nom_words[2] = 32'h01C0_0000;
    rst_a = 1'b1; rst_b = 1'b1;
    rx_data_a = 8'h00; rx_valid_a = 1'b0; start_a = 1'b0;
    rx_data_b = 8'h00; rx_valid_b = 1'b0; start_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_rx_ready", rx_ready_a, 1);
    chk("rst_we", we_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    chk("rst_halt", halt_a, 1);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_words", words_a, 0);
    chk("rst_state", state_a, 0);
    chk("rst_b_halt", halt_b, 1);

    // nominal 3-word load at full rate
    send_word(0, 32'd3, 0);
    for (int k = 0; k < 3; k++) push_send(0, 16'(k), nom_words[k], 0);
    chk("nom_state_done", state_a, 2);
    chk("nom_load_done", done_a, 1);
    chk("nom_rx_ready_done", rx_ready_a, 0);
    chk("nom_last_we", we_a, 1);
    chk("nom_halt_during_last_wr", halt_a, 1);
    @(negedge clk);
    chk("nom_we_low", we_a, 0);
    chk("nom_halt_released", halt_a, 0);
    chk("nom_words", words_a, 3);

    // bytes offered in DONE are not consumed
    rx_data_a = 8'hAA; rx_valid_a = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid_a = 1'b0;
    chk("done_ignore_words", words_a, 3);
    chk("done_ignore_state", state_a, 2);

    // bad header N=0, then recovery with N=1
    pulse_start(0);
    chk("restart_state", state_a, 0);
    chk("restart_halt", halt_a, 1);
    chk("restart_done", done_a, 0);
    chk("restart_words", words_a, 0);
    send_word(0, 32'd0, 0);
    chk("bad_state", state_a, 3);
    chk("bad_err", err_a, 1);
    chk("bad_halt", halt_a, 1);
    chk("bad_rx_ready", rx_ready_a, 0);
    pulse_start(0);
    chk("err_start_state", state_a, 0);
    chk("err_start_err", err_a, 0);
    chk("err_start_rx_ready", rx_ready_a, 1);
    send_word(0, 32'd1, 0);
    push_send(0, 16'd0, 32'h0180_0000, 0);
    chk("n1_done", done_a, 1);
    chk("n1_words", words_a, 1);

    // reload with random gaps; start during LOAD has no effect
    pulse_start(0);
    send_word(0, 32'd3, 5);
    for (int k = 0; k < 3; k++) begin
      push_send(0, 16'(k), nom_words[k], 5);
      if (k == 0) begin
        pulse_start(0);
        chk("load_start_ignored_state", state_a, 1);
        chk("load_start_ignored_words", words_a, 1);
      end
    end
    chk("gap_done", done_a, 1);
    chk("gap_words", words_a, 3);
    repeat (2) @(negedge clk);
    chk("gap_halt", halt_a, 0);

    // reset mid-load after 2nd byte of word 1
    pulse_start(0);
    send_word(0, 32'd3, 0);
    push_send(0, 16'd0, $urandom, 0);
    send_byte(0, 8'hDE);
    send_byte(0, 8'hAD);
    #2 rst_a = 1'b1;
    #1;
    chk("mid_rst_rx_ready", rx_ready_a, 1);
    chk("mid_rst_we", we_a, 0);
    chk("mid_rst_addr", addr_a, 0);
    chk("mid_rst_wdata", wdata_a, 0);
    chk("mid_rst_halt", halt_a, 1);
    chk("mid_rst_words", words_a, 0);
    chk("mid_rst_state", state_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    send_word(0, 32'd2, 3);
    push_send(0, 16'd0, $urandom, 3);
    push_send(0, 16'd1, $urandom, 3);
    chk("fresh_done", done_a, 1);
    chk("fresh_words", words_a, 2);

    // ADDR_WIDTH=2 boundary: N=4 accepted
    send_word(1, 32'd4, 2);
    for (int k = 0; k < 4; k++) push_send(1, 16'(k), $urandom, 2);
    chk("b_n4_done", done_b, 1);
    chk("b_n4_words", words_b, 4);
    // N=5 rejected
    pulse_start(1);
    send_word(1, 32'd5, 0);
    chk("b_n5_state", state_b, 3);
    chk("b_n5_err", err_b, 1);
    chk("b_n5_words", words_b, 0);
    // large N whose low bits look legal is still rejected
    pulse_start(1);
    send_word(1, 32'h0000_0104, 0);
    chk("b_wide_n_state", state_b, 3);

    repeat (3) @(negedge clk);
    chk("a_queue_empty", exp_q_a.size(), 0);
    chk("b_queue_empty", exp_q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
